// File: rtl/alu_cmd_issuer.sv
// alu_cmd_issuer: registers tagged commands into a combinational alu and returns in-order tagged responses
module alu_cmd_issuer #(
    parameter int DATA_WIDTH = 32,
    parameter int TAG_WIDTH  = 4,
    parameter int RSP_DEPTH  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [DATA_WIDTH-1:0] cmd_a,
    input  logic [DATA_WIDTH-1:0] cmd_b,
    input  logic [2:0]            cmd_op,
    input  logic [TAG_WIDTH-1:0]  cmd_tag,
    output logic [DATA_WIDTH-1:0] alu_a,
    output logic [DATA_WIDTH-1:0] alu_b,
    output logic [2:0]            alu_sel,
    input  logic [DATA_WIDTH-1:0] alu_result,
    input  logic                  alu_zero,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_result,
    output logic                  rsp_zero,
    output logic [TAG_WIDTH-1:0]  rsp_tag,
    output logic [31:0]           ops_done
);
    localparam int PW = $clog2(RSP_DEPTH);
    typedef enum logic {IDLE, EXEC} state_t;
    state_t state, state_next;
    logic [TAG_WIDTH-1:0] tag;
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [PW:0] count;
    logic [DATA_WIDTH+TAG_WIDTH:0] mem [RSP_DEPTH];
    logic accept, push, pop;
    assign push = state == EXEC;
    assign pop = rsp_valid && rsp_ready;
    assign cmd_ready = !rst && (int'(count) + int'(push)) < RSP_DEPTH;
    assign accept = cmd_valid && cmd_ready;
    assign rsp_valid = count != '0;
    assign {rsp_result, rsp_zero, rsp_tag} = mem[rd_ptr];
    always_comb state_next = accept ? EXEC : IDLE;
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            alu_a    <= '0;
            alu_b    <= '0;
            alu_sel  <= '0;
            tag      <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            ops_done <= '0;
        end else begin
            state <= state_next;
            if (accept) begin
                alu_a   <= cmd_a;
                alu_b   <= cmd_b;
                alu_sel <= cmd_op;
                tag     <= cmd_tag;
            end
            if (push) begin
                wr_ptr   <= wr_ptr + 1'b1;
                ops_done <= ops_done + 32'd1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + (PW+1)'(push) - (PW+1)'(pop);
        end
    end
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {alu_result, alu_zero, tag};
    end
endmodule

// File: tb/tb_alu_cmd_issuer.sv
// tb_alu_cmd_issuer: directed and randomized checks of alu_cmd_issuer against a behavioural alu
module tb_alu_cmd_issuer;
    logic        clk, rst;
    logic        cmd_valid, cmd_ready;
    logic [31:0] cmd_a, cmd_b;
    logic [2:0]  cmd_op;
    logic [3:0]  cmd_tag;
    logic [31:0] alu_a, alu_b, alu_result;
    logic [2:0]  alu_sel;
    logic        alu_zero;
    logic        rsp_valid, rsp_ready, rsp_zero;
    logic [31:0] rsp_result, ops_done;
    logic [3:0]  rsp_tag;
    int checks = 0;
    int fails = 0;

    typedef struct {
        logic [31:0] r;
        logic        z;
        logic [3:0]  t;
    } exp_t;

    alu_cmd_issuer dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op), .cmd_tag(cmd_tag),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
        .alu_result(alu_result), .alu_zero(alu_zero),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_tag(rsp_tag),
        .ops_done(ops_done)
    );

    function automatic logic [31:0] ref_alu(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
        case (op)
            3'd0: return a + b;
            3'd1: return a - b;
            3'd2: return a & b;
            3'd3: return a | b;
            3'd4: return a ^ b;
            3'd5: return {31'd0, $signed(a) > $signed(b)};
            3'd6: return {31'd0, a > b};
            default: return {31'd0, a == b};
        endcase
    endfunction

    always_comb begin
        alu_result = ref_alu(alu_a, alu_b, alu_sel);
        alu_zero = alu_result == 32'd0;
    end

    initial clk = 0;
    always #5 clk = ~clk;

    task automatic set_cmd(input logic v, input logic [31:0] a, input logic [31:0] b, input logic [2:0] op, input logic [3:0] t);
        cmd_valid = v;
        cmd_a = a;
        cmd_b = b;
        cmd_op = op;
        cmd_tag = t;
    endtask

    task automatic test_reset;
        rst = 1;
        rsp_ready = 0;
        set_cmd(0, 0, 0, 0, 0);
        repeat (2) @(negedge clk);
        checks++;
        if (cmd_ready !== 1'b0) begin fails++; $display("FAIL reset_cmd_ready: got %0b expected 0", cmd_ready); end
        checks++;
        if ({rsp_valid, ops_done} !== 33'd0) begin fails++; $display("FAIL reset_rsp_ops: got valid=%0b ops=%0d expected 0/0", rsp_valid, ops_done); end
        checks++;
        if ({alu_a, alu_b, alu_sel} !== 67'd0) begin fails++; $display("FAIL reset_alu: got a=%0h b=%0h sel=%0d expected zeros", alu_a, alu_b, alu_sel); end
        rst = 0;
        @(negedge clk);
        checks++;
        if (cmd_ready !== 1'b1) begin fails++; $display("FAIL post_reset_ready: got %0b expected 1", cmd_ready); end
    endtask

    task automatic test_add;
        set_cmd(1, 5, 7, 0, 3);
        @(negedge clk);
        set_cmd(0, 0, 0, 0, 0);
        checks++;
        if ({alu_a, alu_b, alu_sel} !== {32'd5, 32'd7, 3'd0}) begin fails++; $display("FAIL add_alu_regs: got a=%0d b=%0d sel=%0d expected 5 7 0", alu_a, alu_b, alu_sel); end
        checks++;
        if (rsp_valid !== 1'b0) begin fails++; $display("FAIL add_early_rsp: got %0b expected 0", rsp_valid); end
        @(negedge clk);
        checks++;
        if ({rsp_valid, rsp_result, rsp_zero, rsp_tag} !== {1'b1, 32'd12, 1'b0, 4'd3}) begin
            fails++; $display("FAIL add_rsp: got v=%0b r=%0d z=%0b t=%0d expected 1 12 0 3", rsp_valid, rsp_result, rsp_zero, rsp_tag);
        end
        checks++;
        if (ops_done !== 32'd1) begin fails++; $display("FAIL add_ops_done: got %0d expected 1", ops_done); end
        rsp_ready = 1;
        @(negedge clk);
        rsp_ready = 0;
        checks++;
        if (rsp_valid !== 1'b0) begin fails++; $display("FAIL add_pop: got %0b expected 0", rsp_valid); end
    endtask

    task automatic test_sub_gt;
        logic [31:0] va [3] = '{32'd9, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] vb [3] = '{32'd9, 32'd1, 32'd1};
        logic [2:0]  vo [3] = '{3'd1, 3'd5, 3'd6};
        logic [3:0]  vt [3] = '{4'd1, 4'd2, 4'd4};
        logic [31:0] er [3] = '{32'd0, 32'd0, 32'd1};
        logic        ez [3] = '{1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 3; i++) begin
            set_cmd(1, va[i], vb[i], vo[i], vt[i]);
            checks++;
            if (cmd_ready !== 1'b1) begin fails++; $display("FAIL subgt_ready[%0d]: got %0b expected 1", i, cmd_ready); end
            @(negedge clk);
        end
        set_cmd(0, 0, 0, 0, 0);
        @(negedge clk);
        checks++;
        if (ops_done !== 32'd4) begin fails++; $display("FAIL subgt_ops_done: got %0d expected 4", ops_done); end
        rsp_ready = 1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({rsp_valid, rsp_result, rsp_zero, rsp_tag} !== {1'b1, er[i], ez[i], vt[i]}) begin
                fails++; $display("FAIL subgt_rsp[%0d]: got v=%0b r=%0h z=%0b t=%0d expected 1 %0h %0b %0d", i, rsp_valid, rsp_result, rsp_zero, rsp_tag, er[i], ez[i], vt[i]);
            end
            @(negedge clk);
        end
        rsp_ready = 0;
        checks++;
        if (rsp_valid !== 1'b0) begin fails++; $display("FAIL subgt_drain: got %0b expected 0", rsp_valid); end
    endtask

    task automatic test_back_to_back;
        logic [31:0] va [8] = '{32'd10, 32'd5, 32'hF0, 32'hF0, 32'hAA, 32'd3, 32'd3, 32'd42};
        logic [31:0] vb [8] = '{32'd20, 32'd8, 32'h0F, 32'h0F, 32'hAA, 32'h8000_0000, 32'h8000_0000, 32'd42};
        logic [31:0] er [8] = '{32'd30, 32'hFFFF_FFFD, 32'd0, 32'hFF, 32'd0, 32'd1, 32'd0, 32'd1};
        logic        ez [8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        rsp_ready = 1;
        for (int c = 0; c < 10; c++) begin
            if (c < 8) begin
                set_cmd(1, va[c], vb[c], 3'(c), 4'(c));
                checks++;
                if (cmd_ready !== 1'b1) begin fails++; $display("FAIL b2b_ready[%0d]: got %0b expected 1", c, cmd_ready); end
            end else set_cmd(0, 0, 0, 0, 0);
            if (c >= 2) begin
                checks++;
                if ({rsp_valid, rsp_result, rsp_zero, rsp_tag} !== {1'b1, er[c-2], ez[c-2], 4'(c-2)}) begin
                    fails++; $display("FAIL b2b_rsp[%0d]: got v=%0b r=%0h z=%0b t=%0d expected 1 %0h %0b %0d", c-2, rsp_valid, rsp_result, rsp_zero, rsp_tag, er[c-2], ez[c-2], c-2);
                end
            end
            @(negedge clk);
        end
        rsp_ready = 0;
        checks++;
        if ({rsp_valid, ops_done} !== {1'b0, 32'd12}) begin fails++; $display("FAIL b2b_end: got v=%0b ops=%0d expected 0 12", rsp_valid, ops_done); end
    endtask

    task automatic test_backpressure;
        int nxt = 0;
        int rcv = 0;
        logic rdy;
        rsp_ready = 0;
        for (int c = 0; c < 8; c++) begin
            set_cmd(1, 32'(nxt), 32'd100, 3'd0, 4'(nxt));
            rdy = cmd_ready;
            @(negedge clk);
            if (rdy) nxt++;
        end
        checks++;
        if (nxt !== 4) begin fails++; $display("FAIL bp_accepts: got %0d expected 4", nxt); end
        for (int c = 0; c < 3; c++) begin
            checks++;
            if ({cmd_ready, rsp_valid, rsp_result, rsp_zero, rsp_tag} !== {1'b0, 1'b1, 32'd100, 1'b0, 4'd0}) begin
                fails++; $display("FAIL bp_hold[%0d]: got rdy=%0b v=%0b r=%0d z=%0b t=%0d expected 0 1 100 0 0", c, cmd_ready, rsp_valid, rsp_result, rsp_zero, rsp_tag);
            end
            @(negedge clk);
        end
        rsp_ready = 1;
        for (int c = 0; c < 200 && rcv < 24; c++) begin
            if (rsp_valid) begin
                checks++;
                if ({rsp_result, rsp_zero, rsp_tag} !== {32'(rcv + 100), 1'b0, 4'(rcv)}) begin
                    fails++; $display("FAIL bp_rsp[%0d]: got r=%0d z=%0b t=%0d expected %0d 0 %0d", rcv, rsp_result, rsp_zero, rsp_tag, rcv + 100, rcv % 16);
                end
                rcv++;
            end
            set_cmd(nxt < 24, 32'(nxt), 32'd100, 3'd0, 4'(nxt));
            rdy = cmd_ready && nxt < 24;
            @(negedge clk);
            if (rdy) nxt++;
        end
        set_cmd(0, 0, 0, 0, 0);
        rsp_ready = 0;
        checks++;
        if (rcv !== 24 || ops_done !== 32'd36) begin fails++; $display("FAIL bp_total: got rcv=%0d ops=%0d expected 24 36", rcv, ops_done); end
    endtask

    task automatic test_random;
        exp_t q[$];
        exp_t e;
        int sent = 0;
        int rcv = 0;
        int cyc = 0;
        logic [31:0] a;
        while ((sent < 1000 || rcv < 1000) && cyc < 20000) begin
            a = $urandom();
            set_cmd(sent < 1000 && $urandom_range(0, 3) != 0, a,
                    ($urandom_range(0, 3) == 0) ? a : $urandom(), 3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)));
            rsp_ready = $urandom_range(0, 2) != 0;
            if (cmd_valid && cmd_ready) begin
                e.r = ref_alu(cmd_a, cmd_b, cmd_op);
                e.z = e.r == 32'd0;
                e.t = cmd_tag;
                q.push_back(e);
                sent++;
            end
            if (rsp_valid && rsp_ready) begin
                checks++;
                if (q.size() == 0) begin
                    fails++; $display("FAIL rand_extra: got response r=%0h t=%0d expected none", rsp_result, rsp_tag);
                end else begin
                    e = q.pop_front();
                    if ({rsp_result, rsp_zero, rsp_tag} !== {e.r, e.z, e.t}) begin
                        fails++; $display("FAIL rand_rsp[%0d]: got r=%0h z=%0b t=%0d expected %0h %0b %0d", rcv, rsp_result, rsp_zero, rsp_tag, e.r, e.z, e.t);
                    end
                end
                rcv++;
            end
            @(negedge clk);
            cyc++;
        end
        set_cmd(0, 0, 0, 0, 0);
        rsp_ready = 0;
        checks++;
        if (rcv !== 1000 || q.size() != 0 || rsp_valid !== 1'b0) begin
            fails++; $display("FAIL rand_total: got rcv=%0d left=%0d v=%0b expected 1000 0 0", rcv, q.size(), rsp_valid);
        end
    endtask

    task automatic test_reset_mid;
        rsp_ready = 0;
        for (int i = 0; i < 4; i++) begin
            set_cmd(1, 32'd7, 32'd1, 3'd0, 4'(i));
            checks++;
            if (cmd_ready !== 1'b1) begin fails++; $display("FAIL rmid_ready[%0d]: got %0b expected 1", i, cmd_ready); end
            @(negedge clk);
        end
        set_cmd(0, 0, 0, 0, 0);
        rst = 1;
        checks++;
        if (cmd_ready !== 1'b0) begin fails++; $display("FAIL rmid_ready_in_rst: got %0b expected 0", cmd_ready); end
        @(negedge clk);
        rst = 0;
        checks++;
        if ({rsp_valid, ops_done, alu_a, alu_b, alu_sel} !== 100'd0) begin
            fails++; $display("FAIL rmid_cleared: got v=%0b ops=%0d a=%0h b=%0h sel=%0d expected zeros", rsp_valid, ops_done, alu_a, alu_b, alu_sel);
        end
        set_cmd(1, 1, 1, 0, 5);
        @(negedge clk);
        set_cmd(0, 0, 0, 0, 0);
        checks++;
        if (rsp_valid !== 1'b0) begin fails++; $display("FAIL rmid_no_partial: got %0b expected 0", rsp_valid); end
        @(negedge clk);
        checks++;
        if ({rsp_valid, rsp_result, rsp_zero, rsp_tag, ops_done} !== {1'b1, 32'd2, 1'b0, 4'd5, 32'd1}) begin
            fails++; $display("FAIL rmid_fresh: got v=%0b r=%0d z=%0b t=%0d ops=%0d expected 1 2 0 5 1", rsp_valid, rsp_result, rsp_zero, rsp_tag, ops_done);
        end
        rsp_ready = 1;
        @(negedge clk);
        rsp_ready = 0;
        checks++;
        if (rsp_valid !== 1'b0) begin fails++; $display("FAIL rmid_drain: got %0b expected 0", rsp_valid); end
    endtask

    initial begin
        test_reset;
        test_add;
        test_sub_gt;
        test_back_to_back;
        test_backpressure;
        test_random;
        test_reset_mid;
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
